bram_pool_buf: RTL and testbench

BRAM_POOL_BUF -- requirements
Module: bram_pool_buf

---
 rtl/bram_pool_buf.sv | 204 ++++++++++++++++++++
 tb/tb_bram_pool_buf.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_pool_buf.sv
// Word buffer on a single-write / single-registered-read block RAM, with
// single-word reads and NUM_SE-word burst fetches. Optional accumulate-write via `BRAM_POOL_ACC_EN.
module bram_pool_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 100352,
  parameter int ADDR_WIDTH = 17,
  parameter int NUM_SE     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        data_in,
`ifdef BRAM_POOL_ACC_EN
  input  logic                         acc_en,
`endif
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rd_ready,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_out_valid,
  input  logic                         se_req,
  input  logic [ADDR_WIDTH-1:0]        se_base_addr,
  output logic                         se_busy,
  output logic [NUM_SE*DATA_WIDTH-1:0] se_data,
  output logic                         se_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int                  SE_W     = NUM_SE * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [4:0]          NUM_SE_W = 5'(NUM_SE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rdata_q;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [4:0]            idx_q, idx_d;
  logic                  cap_pend_q, cap_pend_d;
  logic [3:0]            cap_slot_q, cap_slot_d;
  logic [SE_W-1:0]       se_data_q, se_data_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_oob_q, rd_oob_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  dout_vld_q, dout_vld_d;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  rd_accept;
  logic                  burst_rd;
  logic                  ram_ren;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [ADDR_WIDTH:0]   burst_sum;
  logic [ADDR_WIDTH:0]   burst_wrap;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [ADDR_WIDTH:0]   base_in;
  logic [ADDR_WIDTH:0]   base_fold;

  assign wr_in_range    = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range    = ({1'b0, rd_addr} < DEPTH_W);
  assign se_busy        = (state_q != S_IDLE) && !rst;
  assign se_valid       = (state_q == S_DONE) && !rst;
  assign rd_ready       = !se_busy;
  assign rd_accept      = rd_en && rd_ready;
  assign data_out       = data_out_q;
  assign data_out_valid = dout_vld_q && !rst;
  assign se_data        = se_data_q;

  // Burst address is base+idx folded back into [0, DEPTH); a single subtract
  // suffices because base < DEPTH and idx <= NUM_SE <= DEPTH.
  always_comb begin
    burst_sum  = {1'b0, base_q} + (ADDR_WIDTH+1)'(idx_q);
    burst_wrap = (burst_sum >= DEPTH_W) ? (burst_sum - DEPTH_W) : burst_sum;
    burst_addr = burst_wrap[ADDR_WIDTH-1:0];
    base_in    = {1'b0, se_base_addr};
    base_fold  = (base_in >= DEPTH_W) ? (base_in - DEPTH_W) : base_in;
  end

  assign burst_rd  = (state_q == S_FETCH) && (idx_q < NUM_SE_W);
  assign ram_ren   = burst_rd || (rd_accept && rd_in_range);
  assign ram_raddr = burst_rd ? burst_addr : rd_addr;

`ifdef BRAM_POOL_ACC_EN
  logic                  acc_vld_q, acc_vld_d;
  logic                  acc_add_q, acc_add_d;
  logic [ADDR_WIDTH-1:0] acc_addr_q, acc_addr_d;
  logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d;
  logic                  fwd_hit_q, fwd_hit_d;
  logic [DATA_WIDTH-1:0] fwd_val_q, fwd_val_d;
  logic [DATA_WIDTH-1:0] acc_old_q;
  logic [DATA_WIDTH-1:0] wr_value;

  // Stage 1 reads the old word; stage 2 writes. If stage 2 is writing the
  // address stage 1 reads at the same edge, that fresh value is forwarded.
  always_comb begin
    wr_value   = acc_add_q ? ((fwd_hit_q ? fwd_val_q : acc_old_q) + acc_data_q)
                           : acc_data_q;
    acc_vld_d  = wr_en && wr_in_range;
    acc_add_d  = acc_en;
    acc_addr_d = wr_addr;
    acc_data_d = data_in;
    fwd_hit_d  = acc_vld_q && (acc_addr_q == wr_addr);
    fwd_val_d  = wr_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_vld_q  <= 1'b0;
      acc_add_q  <= 1'b0;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_val_q  <= '0;
    end else begin
      acc_vld_q  <= acc_vld_d;
      acc_add_q  <= acc_add_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_val_q  <= fwd_val_d;
    end
  end
`endif

  // Memory array is never reset; nonblocking read and write give read-first.
  always_ff @(posedge clk) begin
    if (ram_ren) ram_rdata_q <= mem[ram_raddr];
`ifdef BRAM_POOL_ACC_EN
    if (wr_en && wr_in_range) acc_old_q <= mem[wr_addr];
    if (acc_vld_q) mem[acc_addr_q] <= wr_value;
`else
    if (wr_en && wr_in_range) mem[wr_addr] <= data_in;
`endif
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    cap_pend_d = 1'b0;
    cap_slot_d = cap_slot_q;
    se_data_d  = se_data_q;
    if (cap_pend_q) se_data_d[cap_slot_q*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (se_req) begin
          base_d  = base_fold[ADDR_WIDTH-1:0];
          idx_d   = 5'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (burst_rd) begin
          idx_d      = idx_q + 5'd1;
          cap_pend_d = 1'b1;
          cap_slot_d = idx_q[3:0];
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_pend_d  = rd_accept;
    rd_oob_d   = !rd_in_range;
    dout_vld_d = rd_pend_q;
    data_out_d = data_out_q;
    if (rd_pend_q) data_out_d = rd_oob_q ? '0 : ram_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      cap_pend_q <= 1'b0;
      cap_slot_q <= '0;
      se_data_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_oob_q   <= 1'b0;
      data_out_q <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      cap_pend_q <= cap_pend_d;
      cap_slot_q <= cap_slot_d;
      se_data_q  <= se_data_d;
      rd_pend_q  <= rd_pend_d;
      rd_oob_q   <= rd_oob_d;
      data_out_q <= data_out_d;
      dout_vld_q <= dout_vld_d;
    end
  end

endmodule

// File: tb/tb_bram_pool_buf.sv
// Directed self-checking bench for bram_pool_buf: single reads, bursts, wrap,
// busy behaviour, mid-burst reset and (with BRAM_POOL_ACC_EN) accumulate writes.
module tb_bram_pool_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int NSE   = 4;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    data_in;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             rd_ready;
  logic [DW-1:0]    data_out;
  logic             data_out_valid;
  logic             se_req;
  logic [AW-1:0]    se_base_addr;
  logic             se_busy;
  logic [NSE*DW-1:0] se_data;
  logic             se_valid;
`ifdef BRAM_POOL_ACC_EN
  logic             acc_en;
`endif

  int checks = 0;
  int errors = 0;

  bram_pool_buf #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .NUM_SE(NSE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .data_in(data_in),
`ifdef BRAM_POOL_ACC_EN
    .acc_en(acc_en),
`endif
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_ready(rd_ready),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .se_req(se_req),
    .se_base_addr(se_base_addr),
    .se_busy(se_busy),
    .se_data(se_data),
    .se_valid(se_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, advances past the next rising edge, then
  // returns all strobes to idle so the caller samples settled outputs.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic re,
                               input logic [AW-1:0] ra, input logic sr,
                               input logic [AW-1:0] sb);
    wr_en        = we;
    wr_addr      = wa;
    data_in      = wd;
    rd_en        = re;
    rd_addr      = ra;
    se_req       = sr;
    se_base_addr = sb;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    se_req = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues a burst at base, waits (bounded) for se_valid and checks timing and
  // data. With inject set, a single read and a second se_req are driven on the
  // cycle after the request; both must be ignored.
  task automatic runBurst(input string tag, input logic [AW-1:0] base,
                          input logic [127:0] expected, input bit inject);
    int edges;
    int busy_n;
    bit dv_seen;
    edges   = 0;
    busy_n  = 0;
    dv_seen = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, base);
    while (!se_valid && edges < 20) begin
      if (se_busy) busy_n++;
      if (data_out_valid) dv_seen = 1'b1;
      if (inject && edges == 0) begin
        checkOutput({tag, " rd_ready during burst"}, rd_ready, 0);
        applyStimulus(1'b0, '0, '0, 1'b1, 8'd5, 1'b1, 8'd198);
      end else begin
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      end
      edges++;
    end
    checkOutput({tag, " edges to se_valid"}, edges, NSE + 1);
    checkOutput({tag, " busy cycles before valid"}, busy_n, NSE + 1);
    checkOutput({tag, " se_data"}, se_data, expected);
    checkOutput({tag, " se_busy in valid cycle"}, se_busy, 1);
    if (data_out_valid) dv_seen = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    checkOutput({tag, " se_valid after"}, se_valid, 0);
    checkOutput({tag, " se_busy after"}, se_busy, 0);
    checkOutput({tag, " se_data held"}, se_data, expected);
    if (data_out_valid) dv_seen = 1'b1;
    if (inject) checkOutput({tag, " dropped read pulse"}, dv_seen, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_addr      = '0;
    data_in      = '0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    se_req       = 1'b0;
    se_base_addr = '0;
`ifdef BRAM_POOL_ACC_EN
    acc_en       = 1'b0;
`endif
    idleCycles(2);
    checkOutput("reset se_busy", se_busy, 0);
    checkOutput("reset rd_ready", rd_ready, 1);
    checkOutput("reset se_valid", se_valid, 0);
    checkOutput("reset data_out_valid", data_out_valid, 0);
    checkOutput("reset data_out", data_out, 0);
    checkOutput("reset se_data", se_data, 0);
    rst = 1'b0;
    idleCycles(1);

    // Single write then read with one-cycle read latency.
    applyStimulus(1'b1, 8'd10, 32'hA5A5_0001, 1'b0, '0, 1'b0, '0);
    idleCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'd10, 1'b0, '0);
    checkOutput("read valid too early", data_out_valid, 0);
    idleCycles(1);
    checkOutput("read valid", data_out_valid, 1);
    checkOutput("read data", data_out, 32'hA5A5_0001);
    idleCycles(1);
    checkOutput("read valid pulse ends", data_out_valid, 0);

    // Same-edge write and read of one address returns the old word.
    applyStimulus(1'b1, 8'd10, 32'h0000_1234, 1'b1, 8'd10, 1'b0, '0);
    idleCycles(1);
    checkOutput("read-first valid", data_out_valid, 1);
    checkOutput("read-first data", data_out, 32'hA5A5_0001);
    idleCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'd10, 1'b0, '0);
    idleCycles(1);
    checkOutput("read after write data", data_out, 32'h0000_1234);

    // Out-of-range address reads as zero with a valid pulse.
    applyStimulus(1'b1, 8'd250, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, '0);
    idleCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'd250, 1'b0, '0);
    idleCycles(1);
    checkOutput("oob read valid", data_out_valid, 1);
    checkOutput("oob read data", data_out, 0);

    // Burst of four consecutive words.
    applyStimulus(1'b1, 8'd100, 32'd1, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd101, 32'd2, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd102, 32'd3, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd103, 32'd4, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd5, 32'h0000_0055, 1'b0, '0, 1'b0, '0);
    idleCycles(1);
    runBurst("burst100", 8'd100, 128'h00000004_00000003_00000002_00000001, 1'b0);

    // Burst wrapping past the end of the array.
    applyStimulus(1'b1, 8'd198, 32'd7, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd199, 32'd8, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd0, 32'd9, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd1, 32'd10, 1'b0, '0, 1'b0, '0);
    idleCycles(1);
    runBurst("burst wrap", 8'd198, 128'h0000000A_00000009_00000008_00000007, 1'b0);

    // Read and second request during a burst are both dropped.
    runBurst("burst inject", 8'd100, 128'h00000004_00000003_00000002_00000001, 1'b1);

    // Reset landing on the third FETCH cycle aborts the burst.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'd100);
    idleCycles(2);
    checkOutput("mid-burst still busy", se_busy, 1);
    rst = 1'b1;
    idleCycles(1);
    checkOutput("mid-burst reset se_busy", se_busy, 0);
    checkOutput("mid-burst reset se_valid", se_valid, 0);
    checkOutput("mid-burst reset se_data", se_data, 0);
    checkOutput("mid-burst reset rd_ready", rd_ready, 1);
    rst = 1'b0;
    idleCycles(1);
    checkOutput("post-reset idle", se_busy, 0);
    runBurst("burst after reset", 8'd198, 128'h0000000A_00000009_00000008_00000007, 1'b0);

`ifdef BRAM_POOL_ACC_EN
    // Three back-to-back accumulates of 5 onto a zeroed word.
    applyStimulus(1'b1, 8'd20, 32'd0, 1'b0, '0, 1'b0, '0);
    acc_en = 1'b1;
    applyStimulus(1'b1, 8'd20, 32'd5, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd20, 32'd5, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 8'd20, 32'd5, 1'b0, '0, 1'b0, '0);
    acc_en = 1'b0;
    idleCycles(3);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'd20, 1'b0, '0);
    idleCycles(1);
    checkOutput("accumulate result", data_out, 32'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
